// File: rtl/cpri_pkg_arbiter_if.sv
// Handshake bundle between the PRB packet sources and the CPRI write path.
// Source side: i_req/i_vld/i_data/i_last in, o_gnt back; sink side: o_* beat stream, PRB index, error pulses.
interface cpri_pkg_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DW     = 14,
    parameter int CH_W   = 2
);
    logic [NUM_CH-1:0]    i_req;
    logic [NUM_CH-1:0]    o_gnt;
    logic [NUM_CH-1:0]    i_vld;
    logic [NUM_CH*DW-1:0] i_data;
    logic [NUM_CH-1:0]    i_last;
    logic                 o_vld;
    logic                 o_sop;
    logic                 o_eop;
    logic [CH_W-1:0]      o_ch;
    logic [DW-1:0]        o_data;
    logic [8:0]           o_prb_cnt;
    logic                 o_err_short;
    logic                 o_err_long;

    modport master (
        output i_req, i_vld, i_data, i_last,
        input  o_gnt, o_vld, o_sop, o_eop, o_ch, o_data,
        input  o_prb_cnt, o_err_short, o_err_long
    );

    modport slave (
        input  i_req, i_vld, i_data, i_last,
        output o_gnt, o_vld, o_sop, o_eop, o_ch, o_data,
        output o_prb_cnt, o_err_short, o_err_long
    );
endinterface

// File: rtl/cpri_pkg_arbiter.sv
// Round-robin PRB burst scheduler sharing one CPRI write path among NUM_CH sources.
// Ports: i_clk, i_reset (sync, active high), i_hfp (half-frame restart), bus (slave side of cpri_pkg_arbiter_if).
module cpri_pkg_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int DW      = 14,
    parameter int PRB_RE  = 12,
    parameter int NUM_PRB = 132
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_hfp,
    cpri_pkg_arbiter_if.slave bus
);
    localparam int BW = $clog2(PRB_RE);

    typedef enum logic {IDLE, XFER} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   cur;
    logic [CH_W-1:0]   pick;
    logic [CH_W-1:0]   idx;
    logic [BW-1:0]     beat;
    logic [NUM_CH-1:0] gnt;
    logic              vld;
    logic              sop;
    logic              eop;
    logic              err_s;
    logic              err_l;
    logic [CH_W-1:0]   ch;
    logic [DW-1:0]     data;
    logic [8:0]        prb;

    logic              any_req;
    logic              s_vld;
    logic              s_last;
    logic [DW-1:0]     s_data;
    logic              last_beat;
    logic              burst_end;

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (bus.i_req[idx]) pick = idx;
        end
    end

    assign any_req   = |bus.i_req;
    assign s_vld     = bus.i_vld[cur];
    assign s_last    = bus.i_last[cur];
    assign s_data    = bus.i_data[int'(cur) * DW +: DW];
    assign last_beat = (beat == BW'(PRB_RE - 1));
    assign burst_end = s_vld && (last_beat || s_last);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            cur    <= '0;
            beat   <= '0;
            gnt    <= '0;
            vld    <= 1'b0;
            sop    <= 1'b0;
            eop    <= 1'b0;
            err_s  <= 1'b0;
            err_l  <= 1'b0;
            ch     <= '0;
            data   <= '0;
            prb    <= '0;
        end else if (i_hfp) begin
            // Abort without eop/error; o_ch/o_data keep last value.
            state  <= IDLE;
            rr_ptr <= '0;
            beat   <= '0;
            gnt    <= '0;
            vld    <= 1'b0;
            sop    <= 1'b0;
            eop    <= 1'b0;
            err_s  <= 1'b0;
            err_l  <= 1'b0;
            prb    <= '0;
        end else begin
            vld   <= 1'b0;
            sop   <= 1'b0;
            eop   <= 1'b0;
            err_s <= 1'b0;
            err_l <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        cur   <= pick;
                        gnt   <= NUM_CH'(1) << pick;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (s_vld) begin
                        vld   <= 1'b1;
                        ch    <= cur;
                        data  <= s_data;
                        sop   <= (beat == '0);
                        eop   <= last_beat || s_last;
                        err_s <= s_last && !last_beat;
                        err_l <= last_beat && !s_last;
                        if (burst_end) begin
                            state  <= IDLE;
                            gnt    <= '0;
                            beat   <= '0;
                            rr_ptr <= (cur == CH_W'(NUM_CH - 1)) ?
                                      '0 : cur + CH_W'(1);
                            prb    <= (prb == 9'(NUM_PRB - 1)) ?
                                      '0 : prb + 9'd1;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_vld       = vld;
    assign bus.o_sop       = sop;
    assign bus.o_eop       = eop;
    assign bus.o_ch        = ch;
    assign bus.o_data      = data;
    assign bus.o_prb_cnt   = prb;
    assign bus.o_err_short = err_s;
    assign bus.o_err_long  = err_l;
endmodule

// File: tb/tb_cpri_pkg_arbiter.sv
// Directed bench for cpri_pkg_arbiter: reactive sources, output monitor,
// scenario tasks with inline expected values.
module tb_cpri_pkg_arbiter;
    localparam int NUM_CH = 4;
    localparam int DW     = 14;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hfp = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpri_pkg_arbiter_if #(.NUM_CH(NUM_CH), .DW(DW), .CH_W(CH_W)) bus();

    cpri_pkg_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DW(DW),
        .PRB_RE(12), .NUM_PRB(132)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_hfp(hfp),
        .bus(bus)
    );

    // {ch, data, sop, eop, err_short, err_long}
    logic [19:0] beats[$];
    longint      bcyc[$];
    int          gnt_log[$];
    int          gap_log[$];
    longint      cyc = 0;
    int          idle_run = 0;
    logic [3:0]  prev_gnt = '0;
    bit          wrap_mode = 1'b0;
    int          eop_cnt = 0;
    int          es_cnt = 0;
    int          el_cnt = 0;

    function automatic int onehot_idx(input logic [3:0] g);
        int k;
        k = -1;
        case (g)
            4'b0001: k = 0;
            4'b0010: k = 1;
            4'b0100: k = 2;
            4'b1000: k = 3;
            default: k = -1;
        endcase
        return k;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_vld || bus.o_sop || bus.o_eop ||
            bus.o_err_short || bus.o_err_long) begin
            if (!wrap_mode) begin
                beats.push_back({bus.o_ch, bus.o_data, bus.o_sop,
                                 bus.o_eop, bus.o_err_short,
                                 bus.o_err_long});
                bcyc.push_back(cyc);
            end
            eop_cnt += int'(bus.o_eop);
            es_cnt  += int'(bus.o_err_short);
            el_cnt  += int'(bus.o_err_long);
        end
        if (bus.o_gnt != 4'b0 && prev_gnt == 4'b0) begin
            gnt_log.push_back(onehot_idx(bus.o_gnt));
            gap_log.push_back(idle_run);
        end
        idle_run = (bus.o_gnt == 4'b0) ? idle_run + 1 : 0;
        prev_gnt = bus.o_gnt;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        beats.delete();
        bcyc.delete();
        gnt_log.delete();
        gap_log.delete();
    endtask

    // Source model: waits for its grant, then presents beats.
    task automatic send_burst(input int ch, input int nbeats,
                              input int last_at, input bit skew,
                              input bit drop_req, input int abort_at,
                              input bit abort_rst);
        int w;
        w = 0;
        while (bus.o_gnt[ch] !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        checks++;
        if (bus.o_gnt[ch] !== 1'b1) begin
            errors++;
            $display("FAIL grant_wait ch%0d: o_gnt=%b, need bit %0d",
                     ch, bus.o_gnt, ch);
            return;
        end
        if (drop_req) bus.i_req[ch] = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            bus.i_vld[ch] = 1'b1;
            bus.i_data[ch*DW +: DW] = DW'(ch * 256 + b);
            bus.i_last[ch] = (b == last_at);
            if (b == abort_at) begin
                if (abort_rst) rst = 1'b1;
                else hfp = 1'b1;
            end
            step();
            bus.i_vld[ch]  = 1'b0;
            bus.i_last[ch] = 1'b0;
            hfp = 1'b0;
            rst = 1'b0;
            if (b == abort_at) return;
            if (skew && b != nbeats - 1) step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hfp = 1'b0;
        bus.i_req  = '1;
        bus.i_vld  = '1;
        bus.i_last = '0;
        bus.i_data = '1;
        repeat (3) step();
        checks++;
        if ({bus.o_gnt, bus.o_vld, bus.o_sop, bus.o_eop, bus.o_ch,
             bus.o_data, bus.o_prb_cnt, bus.o_err_short,
             bus.o_err_long} !== 34'd0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b vld=%b data=%h prb=%0d, need 0",
                     bus.o_gnt, bus.o_vld, bus.o_data, bus.o_prb_cnt);
        end
        rst = 1'b0;
        bus.i_req  = '0;
        bus.i_vld  = '0;
        bus.i_data = '0;
        step();
        checks++;
        if ({bus.o_gnt, bus.o_vld, bus.o_prb_cnt} !== 14'd0) begin
            errors++;
            $display("FAIL reset_idle: gnt=%b vld=%b prb=%0d, need 0",
                     bus.o_gnt, bus.o_vld, bus.o_prb_cnt);
        end
    endtask

    task automatic test_single();
        logic [19:0] exp;
        clear_logs();
        bus.i_req = 4'b0001;
        step();
        checks++;
        if (bus.o_gnt !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: o_gnt=%b, need 0001", bus.o_gnt);
        end
        send_burst(0, 12, 11, 0, 0, -1, 0);
        bus.i_req = '0;
        checks++;
        if (bus.o_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_gnt_clear: o_gnt=%b, need 0000", bus.o_gnt);
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd1) begin
            errors++;
            $display("FAIL single_prb: got %0d, need 1", bus.o_prb_cnt);
        end
        step();
        checks++;
        if (beats.size() != 12) begin
            errors++;
            $display("FAIL single_count: got %0d beats, need 12", beats.size());
        end
        foreach (beats[i]) begin
            exp = {2'd0, 14'(i), i == 0, i == 11, 2'b00};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL single_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [19:0] exp;
        int ch;
        int b;
        hfp = 1'b1;
        step();
        hfp = 1'b0;
        clear_logs();
        bus.i_req = 4'b1111;
        for (int n = 0; n < 5; n++) send_burst(n % 4, 12, 11, 0, 0, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (gnt_log.size() != 5) begin
            errors++;
            $display("FAIL rr_grants: got %0d grants, need 5", gnt_log.size());
        end
        for (int n = 0; n < gnt_log.size() && n < 5; n++) begin
            checks++;
            if (gnt_log[n] != n % 4) begin
                errors++;
                $display("FAIL rr_order%0d: got %0d, need %0d", n, gnt_log[n], n % 4);
            end
            if (n > 0) begin
                checks++;
                if (gap_log[n] != 1) begin
                    errors++;
                    $display("FAIL rr_gap%0d: got %0d, need 1", n, gap_log[n]);
                end
            end
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd5) begin
            errors++;
            $display("FAIL rr_prb: got %0d, need 5", bus.o_prb_cnt);
        end
        checks++;
        if (beats.size() != 60) begin
            errors++;
            $display("FAIL rr_count: got %0d beats, need 60", beats.size());
        end
        foreach (beats[i]) begin
            ch  = (i / 12) % 4;
            b   = i % 12;
            exp = {2'(ch), 14'(ch * 256 + b), b == 0, b == 11, 2'b00};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL rr_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
    endtask

    task automatic test_skew();
        logic [19:0] exp;
        clear_logs();
        bus.i_req = 4'b0100;
        send_burst(2, 12, 11, 1, 0, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (beats.size() != 12) begin
            errors++;
            $display("FAIL skew_count: got %0d beats, need 12", beats.size());
        end else begin
            checks++;
            if (bcyc[11] - bcyc[0] != 22) begin
                errors++;
                $display("FAIL skew_span: got %0d cycles, need 22", bcyc[11] - bcyc[0]);
            end
        end
        foreach (beats[i]) begin
            exp = {2'd2, 14'(512 + i), i == 0, i == 11, 2'b00};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL skew_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd6) begin
            errors++;
            $display("FAIL skew_prb: got %0d, need 6", bus.o_prb_cnt);
        end
    endtask

    task automatic test_short();
        logic [19:0] exp;
        clear_logs();
        bus.i_req = 4'b1001;
        send_burst(3, 6, 5, 0, 0, -1, 0);
        send_burst(0, 12, 11, 0, 0, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (gnt_log.size() != 2 || gnt_log[0] != 3 || gnt_log[1] != 0 ||
            gap_log[1] != 1) begin
            errors++;
            $display("FAIL short_grants: got %0d grants, need 3 then 0 after 1 idle",
                     gnt_log.size());
        end
        checks++;
        if (beats.size() != 18) begin
            errors++;
            $display("FAIL short_count: got %0d beats, need 18", beats.size());
        end
        foreach (beats[i]) begin
            if (i < 6)
                exp = {2'd3, 14'(768 + i), i == 0, i == 5, i == 5, 1'b0};
            else
                exp = {2'd0, 14'(i - 6), i == 6, i == 17, 2'b00};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL short_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd8) begin
            errors++;
            $display("FAIL short_prb: got %0d, need 8", bus.o_prb_cnt);
        end
    endtask

    task automatic test_long();
        logic [19:0] exp;
        clear_logs();
        bus.i_req = 4'b0010;
        send_burst(1, 14, -1, 0, 1, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (beats.size() != 12) begin
            errors++;
            $display("FAIL long_count: got %0d beats, need 12", beats.size());
        end
        foreach (beats[i]) begin
            exp = {2'd1, 14'(256 + i), i == 0, i == 11, 1'b0, i == 11};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL long_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
        checks++;
        if (gnt_log.size() != 1 || bus.o_gnt !== 4'b0) begin
            errors++;
            $display("FAIL long_regrant: grants=%0d gnt=%b, need 1 and 0000",
                     gnt_log.size(), bus.o_gnt);
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd9) begin
            errors++;
            $display("FAIL long_prb: got %0d, need 9", bus.o_prb_cnt);
        end
    endtask

    task automatic test_hfp();
        logic [19:0] exp;
        clear_logs();
        bus.i_req = 4'b0010;
        step();
        bus.i_req = 4'b1110;
        send_burst(1, 7, -1, 0, 0, 6, 0);
        checks++;
        if ({bus.o_gnt, bus.o_vld, bus.o_eop, bus.o_err_short,
             bus.o_err_long, bus.o_prb_cnt} !== 17'd0) begin
            errors++;
            $display("FAIL hfp_abort: gnt=%b vld=%b eop=%b prb=%0d, need 0",
                     bus.o_gnt, bus.o_vld, bus.o_eop, bus.o_prb_cnt);
        end
        step();
        checks++;
        if (bus.o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL hfp_regrant: o_gnt=%b, need 0010", bus.o_gnt);
        end
        send_burst(1, 12, 11, 0, 0, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (beats.size() != 18 || gap_log.size() != 2 || gap_log[1] != 1) begin
            errors++;
            $display("FAIL hfp_count: got %0d beats %0d grants, need 18 and 2",
                     beats.size(), gap_log.size());
        end
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            exp = {2'd1, 14'(256 + i), i == 0, 3'b000};
            checks++;
            if (beats[i] !== exp) begin
                errors++;
                $display("FAIL hfp_beat%0d: got %h, need %h", i, beats[i], exp);
            end
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd1) begin
            errors++;
            $display("FAIL hfp_prb: got %0d, need 1", bus.o_prb_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        bus.i_req = 4'b0100;
        send_burst(2, 3, -1, 0, 0, 2, 1);
        checks++;
        if ({bus.o_gnt, bus.o_vld, bus.o_sop, bus.o_eop, bus.o_ch,
             bus.o_data, bus.o_prb_cnt, bus.o_err_short,
             bus.o_err_long} !== 34'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: gnt=%b ch=%0d data=%h prb=%0d, need 0",
                     bus.o_gnt, bus.o_ch, bus.o_data, bus.o_prb_cnt);
        end
        bus.i_req = 4'b1010;
        step();
        checks++;
        if (bus.o_gnt !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_ptr: o_gnt=%b, need 0010", bus.o_gnt);
        end
        send_burst(1, 12, 11, 0, 0, -1, 0);
        bus.i_req = '0;
        step();
        checks++;
        if (beats.size() != 14) begin
            errors++;
            $display("FAIL rstmid_count: got %0d beats, need 14", beats.size());
        end
    endtask

    task automatic test_wrap();
        hfp = 1'b1;
        step();
        hfp = 1'b0;
        step();
        clear_logs();
        wrap_mode = 1'b1;
        eop_cnt = 0;
        es_cnt  = 0;
        el_cnt  = 0;
        bus.i_req = 4'b1111;
        for (int n = 0; n < 1848; n++) begin
            send_burst(n % 4, 12, 11, 0, 0, -1, 0);
            if (n == 130) begin
                checks++;
                if (bus.o_prb_cnt !== 9'd131) begin
                    errors++;
                    $display("FAIL wrap_top: got %0d, need 131", bus.o_prb_cnt);
                end
            end
            if (n == 131) begin
                checks++;
                if (bus.o_prb_cnt !== 9'd0) begin
                    errors++;
                    $display("FAIL wrap_zero: got %0d, need 0", bus.o_prb_cnt);
                end
            end
        end
        bus.i_req = '0;
        step();
        wrap_mode = 1'b0;
        checks++;
        if (eop_cnt != 1848) begin
            errors++;
            $display("FAIL wrap_eops: got %0d, need 1848", eop_cnt);
        end
        checks++;
        if (es_cnt + el_cnt != 0) begin
            errors++;
            $display("FAIL wrap_errs: got %0d, need 0", es_cnt + el_cnt);
        end
        checks++;
        if (bus.o_prb_cnt !== 9'd0) begin
            errors++;
            $display("FAIL wrap_final: got %0d, need 0", bus.o_prb_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_skew();
        test_short();
        test_long();
        test_hfp();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
